// File: rtl/int_res_reader.sv
// Read-side sequencer for the IntRes word store: turns a single/double-width
// request into one or two 9-bit storage reads and returns one 18-bit response.
module int_res_reader #(
    parameter int N_ELEM         = 57116,
    parameter int ADDR_W         = $clog2(N_ELEM),
    parameter int WORD_W         = 9,
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                req_double,
    output logic                rsp_valid,
    output logic [2*WORD_W-1:0] rsp_data,
    output logic                rsp_err,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [WORD_W-1:0]   mem_rd_data
);
    typedef enum logic [2:0] {IDLE, ISSUE_LO, ISSUE_HI, WAIT, RESP} state_t;

    localparam logic [ADDR_W:0] LIM_S = (ADDR_W+1)'(N_ELEM);
    localparam logic [ADDR_W:0] LIM_D = (ADDR_W+1)'(N_ELEM - 1);

    state_t                    r_state;
    logic                      r_req_ready;
    logic                      r_rsp_valid;
    logic [2*WORD_W-1:0]       r_rsp_data;
    logic                      r_rsp_err;
    logic                      r_mem_rd_en;
    logic [ADDR_W-1:0]         r_mem_addr;
    logic [ADDR_W-1:0]         r_addr;
    logic                      r_double;
    logic                      r_err;
    logic [WORD_W-1:0]         r_lo;
    // One slot per latency cycle: which issued read (lo/hi) returns when.
    logic [MEM_RD_LATENCY-1:0] r_vld_pipe;
    logic [MEM_RD_LATENCY-1:0] r_hi_pipe;

    logic w_oor;
    logic w_cap;
    logic w_cap_hi;

    assign w_oor    = req_double ? ({1'b0, req_addr} >= LIM_D)
                                 : ({1'b0, req_addr} >= LIM_S);
    assign w_cap    = r_vld_pipe[MEM_RD_LATENCY-1];
    assign w_cap_hi = r_hi_pipe[MEM_RD_LATENCY-1];

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign mem_rd_en = r_mem_rd_en;
    assign mem_addr  = r_mem_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_mem_rd_en <= 1'b0;
            r_mem_addr  <= '0;
            r_addr      <= '0;
            r_double    <= 1'b0;
            r_err       <= 1'b0;
            r_lo        <= '0;
            r_vld_pipe  <= '0;
            r_hi_pipe   <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            for (int i = MEM_RD_LATENCY-1; i > 0; i--) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_hi_pipe[i]  <= r_hi_pipe[i-1];
            end
            r_vld_pipe[0] <= r_mem_rd_en;
            r_hi_pipe[0]  <= (r_state == ISSUE_HI);

            if (w_cap && !w_cap_hi)
                r_lo <= mem_rd_data;

            case (r_state)
                IDLE, RESP: begin
                    if (req_valid) begin
                        r_addr      <= req_addr;
                        r_double    <= req_double;
                        r_req_ready <= 1'b0;
                        r_err       <= w_oor;
                        if (w_oor) begin
                            // Spend one cycle in WAIT so the error pulse lands at T+2.
                            r_state <= WAIT;
                        end else begin
                            r_state     <= ISSUE_LO;
                            r_mem_rd_en <= 1'b1;
                            r_mem_addr  <= req_addr;
                        end
                    end else begin
                        r_state     <= IDLE;
                        r_req_ready <= 1'b1;
                    end
                end
                ISSUE_LO: begin
                    if (r_double) begin
                        r_state     <= ISSUE_HI;
                        r_mem_rd_en <= 1'b1;
                        r_mem_addr  <= r_addr + ADDR_W'(1);
                    end else begin
                        r_state     <= WAIT;
                        r_mem_rd_en <= 1'b0;
                    end
                end
                ISSUE_HI: begin
                    r_state     <= WAIT;
                    r_mem_rd_en <= 1'b0;
                end
                WAIT: begin
                    if (r_err) begin
                        r_state     <= RESP;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                    end else if (w_cap && (w_cap_hi || !r_double)) begin
                        r_state     <= RESP;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_data  <= r_double ? {mem_rd_data, r_lo}
                                                : {{WORD_W{mem_rd_data[WORD_W-1]}}, mem_rd_data};
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_int_res_reader.sv
// Directed bench: one reader at latency 1 and one at latency 3, each fed by
// a small storage model, with hand-computed expected responses and timing.
`timescale 1ns/1ps
module tb_int_res_reader;
    logic        clk = 1'b0;
    logic        rst        [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [15:0] req_addr   [2];
    logic        req_double [2];
    logic        rsp_valid  [2];
    logic [17:0] rsp_data   [2];
    logic        rsp_err    [2];
    logic        mem_rd_en  [2];
    logic [15:0] mem_addr   [2];
    logic [8:0]  mem_rd_data[2];

    logic [8:0]  mem [0:65535];
    logic [8:0]  mp  [2][3];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int rd_n [2];
    int rd_cyc [2][4];
    logic [15:0] rd_adr [2][4];
    int rsp_n [2];
    int rsp_cyc [2][4];
    logic [17:0] rsp_dat [2][4];
    logic rsp_e [2][4];

    int_res_reader #(.MEM_RD_LATENCY(1)) u_dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_double(req_double[0]), .rsp_valid(rsp_valid[0]),
        .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]), .mem_rd_en(mem_rd_en[0]),
        .mem_addr(mem_addr[0]), .mem_rd_data(mem_rd_data[0]));

    int_res_reader #(.MEM_RD_LATENCY(3)) u_dut1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_double(req_double[1]), .rsp_valid(rsp_valid[1]),
        .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]), .mem_rd_en(mem_rd_en[1]),
        .mem_addr(mem_addr[1]), .mem_rd_data(mem_rd_data[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Storage model: returns junk when not read so stale/unexpected captures show up.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            mp[d][0] <= mem_rd_en[d] ? mem[mem_addr[d]] : 9'h1FF;
            mp[d][1] <= mp[d][0];
            mp[d][2] <= mp[d][1];
        end
    end
    assign mem_rd_data[0] = mp[0][0];
    assign mem_rd_data[1] = mp[1][2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_rd_en[d]) begin
                if (rd_n[d] < 4) begin
                    rd_cyc[d][rd_n[d]] = cyc;
                    rd_adr[d][rd_n[d]] = mem_addr[d];
                end
                rd_n[d]++;
            end
            if (rsp_valid[d]) begin
                if (rsp_n[d] < 4) begin
                    rsp_cyc[d][rsp_n[d]] = cyc;
                    rsp_dat[d][rsp_n[d]] = rsp_data[d];
                    rsp_e[d][rsp_n[d]]   = rsp_err[d];
                end
                rsp_n[d]++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr(input int d);
        rd_n[d]  = 0;
        rsp_n[d] = 0;
    endtask

    task automatic send(input int d, input logic [15:0] a, input logic dbl, output int t);
        @(posedge clk); #1;
        req_valid[d] = 1'b1; req_addr[d] = a; req_double[d] = dbl; t = cyc;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
    endtask

    task automatic wait_rsp(input int d, input int n);
        int k;
        k = 0;
        while (rsp_n[d] < n && k < 40) begin
            @(negedge clk); k++;
        end
        if (rsp_n[d] < n) chk("rsp_timeout", 32'(rsp_n[d]), 32'(n));
        repeat (3) @(negedge clk);
    endtask

    int t, t1, t2, busy, n0;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_addr[d] = '0; req_double[d] = 1'b0;
            clr(d);
        end
        mem[16'h0010] = 9'h1F5;
        mem[16'h0100] = 9'h0A3; mem[16'h0101] = 9'h155;
        mem[16'd57114] = 9'h011; mem[16'd57115] = 9'h1E2;
        mem[16'h0020] = 9'h07F;
        mem[16'h0030] = 9'h100;
        mem[16'h0040] = 9'h0AB; mem[16'h0041] = 9'h0CD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready[0]}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
        chk("rst_rsp_data", {14'b0, rsp_data[0]}, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err[0]}, 32'd0);
        chk("rst_rd_en", {31'b0, mem_rd_en[0]}, 32'd0);
        chk("rst_mem_addr", {16'b0, mem_addr[0]}, 32'd0);
        @(posedge clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0;

        // single, negative value, L=1
        clr(0); send(0, 16'h0010, 1'b0, t); wait_rsp(0, 1);
        chk("s_rd_cnt", 32'(rd_n[0]), 32'd1);
        chk("s_rd_cyc", 32'(rd_cyc[0][0]), 32'(t + 1));
        chk("s_rd_addr", {16'b0, rd_adr[0][0]}, 32'h10);
        chk("s_rsp_cyc", 32'(rsp_cyc[0][0]), 32'(t + 3));
        chk("s_rsp_data", {14'b0, rsp_dat[0][0]}, 32'h3FFF5);
        chk("s_rsp_err", {31'b0, rsp_e[0][0]}, 32'd0);

        // double, L=1
        clr(0); send(0, 16'h0100, 1'b1, t); wait_rsp(0, 1);
        chk("d_rd_cnt", 32'(rd_n[0]), 32'd2);
        chk("d_rd0_cyc", 32'(rd_cyc[0][0]), 32'(t + 1));
        chk("d_rd0_addr", {16'b0, rd_adr[0][0]}, 32'h100);
        chk("d_rd1_cyc", 32'(rd_cyc[0][1]), 32'(t + 2));
        chk("d_rd1_addr", {16'b0, rd_adr[0][1]}, 32'h101);
        chk("d_rsp_cyc", 32'(rsp_cyc[0][0]), 32'(t + 4));
        chk("d_rsp_data", {14'b0, rsp_dat[0][0]}, 32'h2AAA3);

        // out of range
        clr(0); send(0, 16'd57116, 1'b0, t); wait_rsp(0, 1);
        chk("oor_s_rd_cnt", 32'(rd_n[0]), 32'd0);
        chk("oor_s_rsp_cyc", 32'(rsp_cyc[0][0]), 32'(t + 2));
        chk("oor_s_err", {31'b0, rsp_e[0][0]}, 32'd1);
        chk("oor_s_data", {14'b0, rsp_dat[0][0]}, 32'd0);
        clr(0); send(0, 16'd57115, 1'b1, t); wait_rsp(0, 1);
        chk("oor_d_rd_cnt", 32'(rd_n[0]), 32'd0);
        chk("oor_d_rsp_cyc", 32'(rsp_cyc[0][0]), 32'(t + 2));
        chk("oor_d_err", {31'b0, rsp_e[0][0]}, 32'd1);
        chk("oor_d_data", {14'b0, rsp_dat[0][0]}, 32'd0);
        clr(0); send(0, 16'd57114, 1'b1, t); wait_rsp(0, 1);
        chk("edge_d_rd_cnt", 32'(rd_n[0]), 32'd2);
        chk("edge_d_rd1_addr", {16'b0, rd_adr[0][1]}, 32'd57115);
        chk("edge_d_rsp_cyc", 32'(rsp_cyc[0][0]), 32'(t + 4));
        chk("edge_d_err", {31'b0, rsp_e[0][0]}, 32'd0);
        chk("edge_d_data", {14'b0, rsp_dat[0][0]}, 32'h3C411);

        // positive single
        clr(0); send(0, 16'h0020, 1'b0, t); wait_rsp(0, 1);
        chk("pos_rsp_data", {14'b0, rsp_dat[0][0]}, 32'h0007F);

        // L=3 back-to-back with req_valid held
        clr(1);
        @(posedge clk); #1;
        req_valid[1] = 1'b1; req_addr[1] = 16'h0030; req_double[1] = 1'b0; t1 = cyc;
        @(posedge clk); #1;
        req_addr[1] = 16'h0040; req_double[1] = 1'b1;
        busy = 0; t2 = -1;
        for (int k = 0; k < 20 && t2 < 0; k++) begin
            @(negedge clk);
            if (req_ready[1]) t2 = cyc;
            else busy++;
            if (t2 < 0) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_rsp(1, 2);
        chk("b2b_accept2", 32'(t2), 32'(t1 + 5));
        chk("b2b_busy", 32'(busy), 32'd4);
        chk("b2b_rsp0_cyc", 32'(rsp_cyc[1][0]), 32'(t1 + 5));
        chk("b2b_rsp0_data", {14'b0, rsp_dat[1][0]}, 32'h3FF00);
        chk("b2b_rsp1_cyc", 32'(rsp_cyc[1][1]), 32'(t2 + 6));
        chk("b2b_rsp1_data", {14'b0, rsp_dat[1][1]}, 32'h19AAB);
        chk("b2b_rd0_cyc", 32'(rd_cyc[1][0]), 32'(t1 + 1));
        chk("b2b_rd1_cyc", 32'(rd_cyc[1][1]), 32'(t2 + 1));
        chk("b2b_rd2_addr", {16'b0, rd_adr[1][2]}, 32'h41);

        // reset in WAIT of a double read, L=3
        clr(1); send(1, 16'h0100, 1'b1, t);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", {31'b0, req_ready[1]}, 32'd1);
        chk("mid_rst_rsp_valid", {31'b0, rsp_valid[1]}, 32'd0);
        n0 = rsp_n[1];
        send(1, 16'h0020, 1'b0, t2); wait_rsp(1, n0 + 1);
        chk("mid_rst_rsp_cnt", 32'(rsp_n[1]), 32'd1);
        chk("mid_rst_rsp_cyc", 32'(rsp_cyc[1][0]), 32'(t2 + 5));
        chk("mid_rst_rsp_data", {14'b0, rsp_dat[1][0]}, 32'h0007F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/int_res_reader.md
Name: int_res_reader

Overview:
- Read-side controller for the intermediate-result (IntRes) storage of the centralized CIM.
- Accepts single-width (9 b) or double-width (18 b) read requests from compute datapaths and sequences one or two word reads on the 9-bit storage read port.
- Absorbs the fixed storage read latency and returns one assembled 18-bit response per request.
- Sits between the central controller/compute units and the IntRes SRAM read port. It is the reader counterpart to the IntRes write path.

Parameters:
- N_ELEM, 57116, number of 9-bit words in IntRes storage.
- ADDR_W, $clog2(N_ELEM) = 16, address width.
- WORD_W, 9, storage word width (N_STO_INT_RES).
- MEM_RD_LATENCY, 1, cycles from mem_rd_en to valid mem_rd_data. Legal range is 1..3.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  read request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  ADDR_W  word address (low word for double).
- req_double  in  1  1 = double-width read, 0 = single-width read.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  2*WORD_W  response data.
- rsp_err  out  1  address out of range; qualified by rsp_valid.
- mem_rd_en  out  1  storage read strobe.
- mem_addr  out  ADDR_W  storage read address.
- mem_rd_data  in  WORD_W  storage read data, valid MEM_RD_LATENCY cycles after mem_rd_en.

Behaviour:
- Reset state:
  - req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, mem_rd_en=0, mem_addr=0.
  - FSM goes to IDLE; the latency counter is cleared.
- Reset mid-operation:
  - Abort immediately, with no rsp_valid.
  - In-flight mem_rd_data is ignored.
- FSM states: IDLE, ISSUE_LO, ISSUE_HI, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On accept in cycle T: latch addr and double, then go to ISSUE_LO.
  - Out-of-range request goes to RESP instead, with err set and no memory access.
  - Out of range means: single with addr >= N_ELEM, or double with addr >= N_ELEM-1.
- ISSUE_LO (T+1):
  - mem_rd_en=1, mem_addr=addr.
  - Next state is ISSUE_HI if double, else WAIT.
- ISSUE_HI (T+2):
  - mem_rd_en=1, mem_addr=addr+1.
  - Next state is WAIT.
- WAIT: count down MEM_RD_LATENCY cycles.
  - Capture lo word at T+1+L.
  - Capture hi word at T+2+L.
  - Go to RESP after the final capture.
- RESP:
  - Single: rsp_valid=1 at T+2+L; double: at T+3+L. Out-of-range: at T+2.
  - Return to IDLE; req_ready is 1 in the same cycle as rsp_valid.
  - A new request may be accepted in that cycle.
- req_ready=0 in every state except IDLE and RESP. Requests presented while req_ready=0 are held by the requester (valid/ready rule).
- mem_rd_en is high only in ISSUE_LO/ISSUE_HI. mem_addr holds its last value otherwise.
- Data assembly:
  - Single: rsp_data = sign-extend(lo) to 18 b.
  - Double: rsp_data = {hi, lo}, where hi is the word at addr+1.
  - Error: rsp_data = 0, rsp_err=1.
- rsp_data and rsp_err hold until the next response. rsp_valid is a pulse. There is no response backpressure.
- Address arithmetic: addr+1 is computed in ADDR_W bits. It never wraps, because the range check precedes issue.

Test Plan:
- Single read, L=1, req_addr=0x0010, mem returns 9'h1F5 -> one mem_rd_en at T+1 (addr 0x0010); rsp_valid at T+3; rsp_data=18'h3FFF5; rsp_err=0.
- Double read, L=1, req_addr=0x0100, mem lo=9'h0A3 and hi=9'h155 -> mem_rd_en at T+1 (0x0100) and T+2 (0x0101); rsp_valid at T+4; rsp_data=18'h2AAA3.
- Out-of-range requests:
  - single addr=57116 -> no mem_rd_en; rsp_valid at T+2, rsp_err=1, rsp_data=0.
  - double addr=57115 -> same.
  - double addr=57114 -> normal read of 57114/57115.
- L=3 back-to-back: single then double, with req_valid held -> second accepted in the first's RESP cycle; response spacing matches T+2+L and T+3+L; req_ready=0 while busy.
- Reset mid-op: assert rst in WAIT of a double read -> next cycle req_ready=1, no rsp_valid, later stale mem_rd_data ignored; next single read returns correct data.
- Positive single value: mem returns 9'h07F -> rsp_data=18'h0007F.
